// File: rtl/timer_arbiter_pkg.sv
// timer_arbiter_pkg: state encoding and countdown constants shared by the timer arbiter and its bench.
package timer_arbiter_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
   localparam int CNT_W_DEF = 3;
   localparam logic [CNT_W_DEF-1:0] CNT_ONES = '1;
endpackage

// File: rtl/timer_arbiter_if.sv
// timer_arbiter_if: request/grant bundle between two requesters and the shared countdown.
interface timer_arbiter_if #(parameter int CNT_W = 3);
   logic [1:0] req;
   logic [CNT_W-1:0] len0;
   logic [CNT_W-1:0] len1;
   logic [1:0] grant;
   logic [1:0] done;
   logic busy;
   logic [CNT_W-1:0] count;
   modport master(output req, len0, len1, input grant, done, busy, count);
   modport slave(input req, len0, len1, output grant, done, busy, count);
endinterface

// File: rtl/timer_arbiter_tick_down_core.sv
// tick_down_core: loadable countdown that saturates at 0 and resets to all-ones.
module tick_down_core
   import timer_arbiter_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             en,
   output logic [CNT_W-1:0] count,
   output logic             zero
);
   logic [CNT_W-1:0] count_q, count_d;
   always_comb count_d = load ? load_val : (en && count_q != '0) ? count_q - CNT_W'(1) : count_q;
   always_ff @(posedge clk or posedge rst)
      if (rst) count_q <= '1;
      else count_q <= count_d;
   assign count = count_q;
   assign zero = count_q == '0;
endmodule

// File: rtl/timer_arbiter.sv
// timer_arbiter: round-robin owner of a shared countdown for two requesters.
// Define TIMER_ARBITER_ABORT_EN to let the owner abort a run by dropping its request.
module timer_arbiter
   import timer_arbiter_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input logic clk,
   input logic rst,
   timer_arbiter_if.slave bus
);
   state_e state_q, state_d;
   logic [1:0] grant_q, grant_d, done_q, done_d;
   logic last_q, last_d;
   logic load, en, zero, win;
   logic [CNT_W-1:0] load_val;
   // last_q is the requester served most recently; the other one wins a tie
   assign win = (bus.req == 2'b11) ? ~last_q : bus.req[1];
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      done_d = '0;
      last_d = last_q;
      load = 1'b0;
      load_val = win ? bus.len1 : bus.len0;
      en = 1'b0;
      unique case (state_q)
         IDLE: if (|bus.req) begin
            state_d = RUN;
            grant_d = win ? 2'b10 : 2'b01;
            load = 1'b1;
         end
         RUN: begin
            en = 1'b1;
            if (zero) begin
               state_d = DONE;
               done_d = grant_q;
            end
`ifdef TIMER_ARBITER_ABORT_EN
            if (~|(bus.req & grant_q)) begin
               state_d = IDLE;
               grant_d = '0;
               done_d = '0;
               load = 1'b1;
               load_val = '1;
               last_d = grant_q[1];
            end
`endif
         end
         DONE: begin
            state_d = IDLE;
            grant_d = '0;
            last_d = grant_q[1];
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q <= IDLE;
         grant_q <= '0;
         done_q <= '0;
         last_q <= 1'b1;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         done_q <= done_d;
         last_q <= last_d;
      end
   tick_down_core #(.CNT_W(CNT_W)) u_core (
      .clk(clk),
      .rst(rst),
      .load(load),
      .load_val(load_val),
      .en(en),
      .count(bus.count),
      .zero(zero)
   );
   assign bus.grant = grant_q;
   assign bus.done = done_q;
   assign bus.busy = state_q != IDLE;
endmodule

// File: tb/tb_timer_arbiter.sv
// tb_timer_arbiter: scoreboard bench for timer_arbiter; honours TIMER_ARBITER_ABORT_EN like the design.
module tb_timer_arbiter;
   import timer_arbiter_pkg::*;
   localparam int CNT_W = CNT_W_DEF;
   typedef struct {
      logic [1:0] g;
      logic [1:0] d;
      logic [CNT_W-1:0] c;
   } exp_t;
   logic clk = 1'b0;
   logic rst;
   int n_run = 0;
   int n_fail = 0;
   exp_t exp_q[$];
   timer_arbiter_if #(.CNT_W(CNT_W)) bus ();
   timer_arbiter #(.CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask
   task automatic push(input logic [1:0] g, input logic [1:0] d, input logic [CNT_W-1:0] c);
      exp_q.push_back('{g: g, d: d, c: c});
   endtask
   task automatic drain(input string tag);
      exp_t e;
      while (exp_q.size() > 0) begin
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         chk({tag, ".grant"}, 8'(bus.grant), 8'(e.g));
         chk({tag, ".done"}, 8'(bus.done), 8'(e.d));
         chk({tag, ".busy"}, 8'(bus.busy), 8'(|e.g));
         chk({tag, ".count"}, 8'(bus.count), 8'(e.c));
      end
   endtask
   task automatic chk_reset(input string tag);
      chk({tag, ".grant"}, 8'(bus.grant), 8'h0);
      chk({tag, ".done"}, 8'(bus.done), 8'h0);
      chk({tag, ".busy"}, 8'(bus.busy), 8'h0);
      chk({tag, ".count"}, 8'(bus.count), 8'(CNT_ONES));
   endtask
   initial begin
      rst = 1'b1;
      bus.req = 2'b00;
      bus.len0 = '0;
      bus.len1 = '0;
      #10;
      chk_reset("reset");
      #2;
      rst = 1'b0;
      bus.req = 2'b11;
      bus.len0 = 3'd1;
      bus.len1 = 3'd2;
      push(2'b01, 2'b00, 3'd1);
      push(2'b01, 2'b00, 3'd0);
      push(2'b01, 2'b01, 3'd0);
      drain("cont0");
      bus.req = 2'b10;
      push(2'b00, 2'b00, 3'd0);
      push(2'b10, 2'b00, 3'd2);
      drain("cont_gap");
      bus.len1 = 3'd5;
      push(2'b10, 2'b00, 3'd1);
      push(2'b10, 2'b00, 3'd0);
      push(2'b10, 2'b10, 3'd0);
      drain("cont1");
      bus.req = 2'b11;
      push(2'b00, 2'b00, 3'd0);
      push(2'b01, 2'b00, 3'd1);
      push(2'b01, 2'b00, 3'd0);
      push(2'b01, 2'b01, 3'd0);
      drain("cont_rr");
      bus.req = 2'b10;
      bus.len1 = 3'd0;
      push(2'b00, 2'b00, 3'd0);
      push(2'b10, 2'b00, 3'd0);
      push(2'b10, 2'b10, 3'd0);
      drain("zero_len");
      bus.req = 2'b01;
      bus.len0 = 3'd3;
      push(2'b00, 2'b00, 3'd0);
      push(2'b01, 2'b00, 3'd3);
      push(2'b01, 2'b00, 3'd2);
      push(2'b01, 2'b00, 3'd1);
      push(2'b01, 2'b00, 3'd0);
      push(2'b01, 2'b01, 3'd0);
      drain("single");
      bus.req = 2'b00;
      push(2'b00, 2'b00, 3'd0);
      push(2'b00, 2'b00, 3'd0);
      drain("idle_hold");
      bus.req = 2'b01;
      bus.len0 = 3'd4;
      push(2'b01, 2'b00, 3'd4);
      push(2'b01, 2'b00, 3'd3);
      push(2'b01, 2'b00, 3'd2);
      drain("pre_rst");
      #2;
      rst = 1'b1;
      #1;
      chk_reset("mid_rst");
      push(2'b00, 2'b00, CNT_ONES);
      push(2'b00, 2'b00, CNT_ONES);
      drain("rst_hold");
      rst = 1'b0;
      push(2'b01, 2'b00, 3'd4);
      push(2'b01, 2'b00, 3'd3);
      push(2'b01, 2'b00, 3'd2);
      drain("pre_abort");
      bus.req = 2'b00;
`ifdef TIMER_ARBITER_ABORT_EN
      push(2'b00, 2'b00, CNT_ONES);
      push(2'b00, 2'b00, CNT_ONES);
      drain("abort");
`else
      push(2'b01, 2'b00, 3'd1);
      push(2'b01, 2'b00, 3'd0);
      push(2'b01, 2'b01, 3'd0);
      push(2'b00, 2'b00, 3'd0);
      drain("no_abort");
`endif
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
